adc2fifo_pack: RTL and testbench

//  Write side of the ADC/FIFO path: packs 16-bit Intan ADC samples into an 8-bit

---
 rtl/adc2fifo_pack_if.sv | 32 +++
 rtl/adc2fifo_pack.sv | 200 ++++++++++++++++++++
 tb/tb_adc2fifo_pack.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc2fifo_pack_if.sv
// rtl/adc2fifo_pack_if.sv - frame handshake, ADC sample and FIFO write signals of adc2fifo_pack
interface adc2fifo_pack_if;
    logic        fs_fifo;
    logic        fd_fifo;
    logic        adc_rxen;
    logic [15:0] adc_rxd;
    logic        fifo_full;
    logic        fifo_txen;
    logic [7:0]  fifo_txd;

    // packer side: consumes frame requests and samples, drives the FIFO write port
    modport master (
        input  fs_fifo,
        output fd_fifo,
        input  adc_rxen,
        input  adc_rxd,
        input  fifo_full,
        output fifo_txen,
        output fifo_txd
    );

    // environment side: frame requester, ADC receiver and FIFO
    modport slave (
        output fs_fifo,
        input  fd_fifo,
        output adc_rxen,
        output adc_rxd,
        output fifo_full,
        input  fifo_txen,
        input  fifo_txd
    );
endinterface

// File: rtl/adc2fifo_pack.sv
// rtl/adc2fifo_pack.sv - packs 16-bit ADC samples into framed FIFO bytes; ADC2FIFO_SUM_EN adds an XOR tail byte
module adc2fifo_pack #(
    parameter int unsigned CHAN_NUM  = 32,
    parameter logic [7:0]  HEAD_BYTE = 8'hAA
) (
    input  logic            clk,
    input  logic            rst_n,
    adc2fifo_pack_if.master bus,
    output logic [7:0]      frame_cnt,
    output logic            err_ovf
);

    localparam logic [7:0] LAST_CHAN = 8'(CHAN_NUM - 1);

`ifdef ADC2FIFO_SUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HEAD, S_NUM, S_WAIT, S_DATH, S_DATL, S_TAIL, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HEAD, S_NUM, S_WAIT, S_DATH, S_DATL, S_DONE
    } state_t;
`endif

    state_t      state_q,     state_d;
    logic        txen_q,      txen_d;
    logic [7:0]  txd_q,       txd_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  chan_cnt_q,  chan_cnt_d;
    logic        err_q,       err_d;
    logic [15:0] sample_q,    sample_d;
    logic [15:0] skid_q,      skid_d;
    logic        skid_full_q, skid_full_d;
`ifdef ADC2FIFO_SUM_EN
    logic [7:0]  sum_q,       sum_d;
`endif

    logic        frame_active;
    logic        can_write;

    assign frame_active = (state_q != S_IDLE) && (state_q != S_DONE);
    assign can_write    = !bus.fifo_full;

    // next-state, write data and bookkeeping; abort takes priority over any write
    always_comb begin
        state_d     = state_q;
        txen_d      = 1'b0;
        txd_d       = txd_q;
        frame_cnt_d = frame_cnt_q;
        chan_cnt_d  = chan_cnt_q;
        err_d       = err_q;
        sample_d    = sample_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
`ifdef ADC2FIFO_SUM_EN
        sum_d       = sum_q;
`endif

        if (frame_active && !bus.fs_fifo) begin
            // requester withdrew: leave the partial frame in the FIFO, drop any buffered sample
            state_d     = S_IDLE;
            skid_full_d = 1'b0;
        end else begin
            // a sample arriving while we are busy writing goes to the one-entry skid
            if (frame_active && (state_q != S_WAIT) && bus.adc_rxen) begin
                if (skid_full_q) begin
                    err_d = 1'b1;
                end else begin
                    skid_d      = bus.adc_rxd;
                    skid_full_d = 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (bus.fs_fifo) begin
                        state_d    = S_HEAD;
                        chan_cnt_d = 8'd0;
`ifdef ADC2FIFO_SUM_EN
                        sum_d      = 8'd0;
`endif
                    end
                end
                S_HEAD: begin
                    if (can_write) begin
                        txen_d  = 1'b1;
                        txd_d   = HEAD_BYTE;
                        state_d = S_NUM;
                    end
                end
                S_NUM: begin
                    if (can_write) begin
                        txen_d  = 1'b1;
                        txd_d   = frame_cnt_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (skid_full_q) begin
                        // buffered sample first; a sample arriving now refills the skid
                        sample_d    = skid_q;
                        skid_full_d = bus.adc_rxen;
                        if (bus.adc_rxen) begin
                            skid_d = bus.adc_rxd;
                        end
                        state_d = S_DATH;
                    end else if (bus.adc_rxen) begin
                        sample_d = bus.adc_rxd;
                        state_d  = S_DATH;
                    end
                end
                S_DATH: begin
                    if (can_write) begin
                        txen_d  = 1'b1;
                        txd_d   = sample_q[15:8];
`ifdef ADC2FIFO_SUM_EN
                        sum_d   = sum_q ^ sample_q[15:8];
`endif
                        state_d = S_DATL;
                    end
                end
                S_DATL: begin
                    if (can_write) begin
                        txen_d     = 1'b1;
                        txd_d      = sample_q[7:0];
`ifdef ADC2FIFO_SUM_EN
                        sum_d      = sum_q ^ sample_q[7:0];
`endif
                        chan_cnt_d = chan_cnt_q + 8'd1;
                        if (chan_cnt_q == LAST_CHAN) begin
`ifdef ADC2FIFO_SUM_EN
                            state_d = S_TAIL;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
`ifdef ADC2FIFO_SUM_EN
                S_TAIL: begin
                    if (can_write) begin
                        txen_d  = 1'b1;
                        txd_d   = sum_q;
                        state_d = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (!bus.fs_fifo) begin
                        state_d     = S_IDLE;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            txen_q      <= 1'b0;
            txd_q       <= 8'd0;
            frame_cnt_q <= 8'd0;
            chan_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            sample_q    <= 16'd0;
            skid_q      <= 16'd0;
            skid_full_q <= 1'b0;
`ifdef ADC2FIFO_SUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            txen_q      <= txen_d;
            txd_q       <= txd_d;
            frame_cnt_q <= frame_cnt_d;
            chan_cnt_q  <= chan_cnt_d;
            err_q       <= err_d;
            sample_q    <= sample_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
`ifdef ADC2FIFO_SUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.fd_fifo   = (state_q == S_DONE);
    assign bus.fifo_txen = txen_q;
    assign bus.fifo_txd  = txd_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_ovf       = err_q;

endmodule

// File: tb/tb_adc2fifo_pack.sv
// tb/tb_adc2fifo_pack.sv - directed self-checking bench for adc2fifo_pack
module tb_adc2fifo_pack;

    localparam int CH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] frame_cnt;
    logic       err_ovf;

    always #5 clk = ~clk;

    adc2fifo_pack_if bus();

    adc2fifo_pack #(
        .CHAN_NUM  (CH),
        .HEAD_BYTE (8'hAA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .err_ovf   (err_ovf)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit         fd_seen;
    int         cnt;

    // capture every FIFO write and any frame-done indication
    always @(negedge clk) begin
        if (bus.fifo_txen) got.push_back(bus.fifo_txd);
        if (bus.fd_fifo) fd_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] d);
        bus.adc_rxd  = d;
        bus.adc_rxen = 1'b1;
        tick(1);
        bus.adc_rxen = 1'b0;
    endtask

    // raise fs_fifo and let HEAD and NUM go out; returns with the packer in WAIT
    task automatic start_frame();
        bus.fs_fifo = 1'b1;
        tick(4);
    endtask

    // one sample from WAIT through DATH and DATL
    task automatic feed(input logic [15:0] d);
        pulse(d);
        tick(2);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.fd_fifo && n < 40) begin
            tick(1);
            n++;
        end
        check({tag, "_fd"}, 32'(bus.fd_fifo), 32'd1);
    endtask

    task automatic end_frame();
        bus.fs_fifo = 1'b0;
        tick(1);
    endtask

    task automatic exp_frame(input logic [7:0] idx, input logic [15:0] a, input logic [15:0] b);
        exp_q = {};
        exp_q.push_back(8'hAA);
        exp_q.push_back(idx);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(b[7:0]);
`ifdef ADC2FIFO_SUM_EN
        exp_q.push_back(a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0]);
`endif
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b);
        start_frame();
        feed(a);
        feed(b);
        wait_done(tag);
        end_frame();
    endtask

    initial begin
        bus.fs_fifo   = 1'b0;
        bus.adc_rxen  = 1'b0;
        bus.adc_rxd   = 16'd0;
        bus.fifo_full = 1'b0;
        rst_n         = 1'b0;
        fd_seen       = 1'b0;
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_fd",   32'(bus.fd_fifo),   32'd0);
        check("rst_txen", 32'(bus.fifo_txen), 32'd0);
        check("rst_txd",  32'(bus.fifo_txd),  32'd0);
        check("rst_fcnt", 32'(frame_cnt),     32'd0);
        check("rst_err",  32'(err_ovf),       32'd0);

        // basic frame with HEAD latency of two cycles
        @(posedge clk); #1;
        got = {};
        bus.fs_fifo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_n1_txen", 32'(bus.fifo_txen), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_n2_txen", 32'(bus.fifo_txen), 32'd1);
        check("lat_n2_txd",  32'(bus.fifo_txd),  32'hAA);
        tick(2);
        feed(16'h1234);
        feed(16'hABCD);
        wait_done("f1");
        end_frame();
        check("f1_fd_low", 32'(bus.fd_fifo), 32'd0);
        check("f1_fcnt",   32'(frame_cnt),   32'd1);
`ifdef ADC2FIFO_SUM_EN
        exp_q = {8'hAA, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
`else
        exp_q = {8'hAA, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
        check_stream("f1");

        // FIFO full for five cycles while in DATH
        got = {};
        start_frame();
        bus.adc_rxd  = 16'hC3E1;
        bus.adc_rxen = 1'b1;
        tick(1);
        bus.adc_rxen  = 1'b0;
        bus.fifo_full = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick(1);
            if (bus.fifo_txen) cnt++;
        end
        bus.fifo_full = 1'b0;
        check("full_txen_cnt", 32'(cnt), 32'd0);
        tick(1);
        check("full_rel_txen", 32'(bus.fifo_txen), 32'd1);
        check("full_rel_txd",  32'(bus.fifo_txd),  32'hC3);
        tick(2);
        feed(16'h0F70);
        wait_done("f2");
        end_frame();
        check("f2_fcnt", 32'(frame_cnt), 32'd2);
        exp_frame(8'h01, 16'hC3E1, 16'h0F70);
        check_stream("f2");

        // skid buffer and overflow while the FIFO is held full
        got = {};
        start_frame();
        bus.adc_rxd  = 16'h1111;
        bus.adc_rxen = 1'b1;
        tick(1);
        bus.adc_rxen  = 1'b0;
        bus.fifo_full = 1'b1;
        tick(1);
        pulse(16'h2222);
        tick(1);
        check("ovf_after2", 32'(err_ovf), 32'd0);
        pulse(16'h3333);
        tick(1);
        check("ovf_after3", 32'(err_ovf), 32'd1);
        bus.fifo_full = 1'b0;
        wait_done("f3");
        end_frame();
        check("ovf_sticky", 32'(err_ovf), 32'd1);
        exp_frame(8'h02, 16'h1111, 16'h2222);
        check_stream("f3");

        // reset while in DATL
        start_frame();
        pulse(16'hBEEF);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check("rdl_txen", 32'(bus.fifo_txen), 32'd0);
        check("rdl_txd",  32'(bus.fifo_txd),  32'd0);
        check("rdl_fd",   32'(bus.fd_fifo),   32'd0);
        check("rdl_fcnt", 32'(frame_cnt),     32'd0);
        check("rdl_err",  32'(err_ovf),       32'd0);
        rst_n       = 1'b1;
        bus.fs_fifo = 1'b0;
        tick(2);

        // abort after the first sample
        got = {};
        fd_seen = 1'b0;
        start_frame();
        feed(16'h4321);
        bus.fs_fifo = 1'b0;
        tick(4);
        check("abt_fd_seen", 32'(fd_seen),       32'd0);
        check("abt_fcnt",    32'(frame_cnt),     32'd0);
        check("abt_txen",    32'(bus.fifo_txen), 32'd0);
        exp_q = {8'hAA, 8'h00, 8'h43, 8'h21};
        check_stream("abt");

        // abort and FIFO release in the same cycle: no write
        got = {};
        bus.fifo_full = 1'b1;
        bus.fs_fifo   = 1'b1;
        tick(4);
        check("abf_held", 32'(got.size()), 32'd0);
        bus.fs_fifo   = 1'b0;
        bus.fifo_full = 1'b0;
        tick(4);
        check("abf_nowrite", 32'(got.size()), 32'd0);
        check("abf_fd_seen", 32'(fd_seen),    32'd0);

        // 256 frames wrap the index, then one more frame carries index 0
        for (int i = 0; i < 256; i++) begin
            got = {};
            run_frame("wr", 16'(i * 3), 16'(i + 16'h0100));
            tick(1);
            if (got.size() > 1) check("wr_num", 32'(got[1]), 32'(i));
            else check("wr_num_len", 32'(got.size()), 32'd6);
            check("wr_fcnt", 32'(frame_cnt), 32'((i + 1) % 256));
        end
        check("wrap_fcnt", 32'(frame_cnt), 32'd0);
        got = {};
        run_frame("f257", 16'h5AA5, 16'h00FF);
        tick(1);
        exp_frame(8'h00, 16'h5AA5, 16'h00FF);
        check_stream("f257");
        check("f257_fcnt", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
